// File: rtl/iter_seq_counter.sv
// -----------------------------------------------------------------------------
// iter_seq_counter
// Multi-channel iteration sequencer for the iterative multiply/divide units.
// Each channel runs an independent start/busy/done handshake with a terminal
// count latched at start, step gating, abort, and a look-ahead "last" flag.
//
// Optional feature macro: ITER_SEQ_PERF_EN
//   When defined, adds done_total: a saturating 16-bit per-channel count of
//   done pulses, cleared only by rst.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   [NUM_CH]        per-channel start request
//   step       in   [NUM_CH]        per-channel advance enable
//   abort      in   [NUM_CH]        per-channel cancel
//   term_cnt   in   [NUM_CH*CNT_W]  per-channel terminal count, slice i*CNT_W
//   count      out  [NUM_CH*CNT_W]  current iteration index (registered)
//   busy       out  [NUM_CH]        channel running (registered)
//   last       out  [NUM_CH]        combinational: busy & (count == term)
//   done       out  [NUM_CH]        one-cycle completion pulse (registered)
//   done_total out  [NUM_CH*16]     done pulse counters (ITER_SEQ_PERF_EN only)
// -----------------------------------------------------------------------------
module iter_seq_counter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         step,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [NUM_CH*CNT_W-1:0]   term_cnt,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         last,
`ifdef ITER_SEQ_PERF_EN
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*16-1:0]      done_total
`else
  output logic [NUM_CH-1:0]         done
`endif
);

  localparam int unsigned PERF_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   r_term;
    logic [CNT_W-1:0]   w_term_nxt;
    logic [CNT_W-1:0]   w_term_in;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_at_term;

    assign w_term_in = term_cnt[gi*CNT_W +: CNT_W];
    assign w_at_term = (r_count == r_term);

    // Channel state registers
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_term  <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_count <= w_count_nxt;
        r_term  <= w_term_nxt;
        r_busy  <= w_busy_nxt;
        r_done  <= w_done_nxt;
      end
    end

    // Next-state: IDLE accepts start unless aborted; RUN priority abort > step > hold
    always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_term_nxt  = r_term;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start[gi] && !abort[gi]) begin
            w_term_nxt  = w_term_in;
            w_count_nxt = '0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort[gi]) begin
            w_count_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else if (step[gi]) begin
            if (w_at_term) begin
              w_count_nxt = '0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_count_nxt = r_count + CNT_W'(1);
            end
          end
        end
      endcase
    end

    assign count[gi*CNT_W +: CNT_W] = r_count;
    assign busy[gi]                 = r_busy;
    assign done[gi]                 = r_done;
    // Look-ahead: the next accepted step will complete the run
    assign last[gi]                 = r_busy & w_at_term;

`ifdef ITER_SEQ_PERF_EN
    logic [PERF_W-1:0] r_done_total;

    // Saturating completion counter, updated on the same edge done is raised
    always_ff @(posedge clk) begin
      if (rst) begin
        r_done_total <= '0;
      end else if (w_done_nxt && (r_done_total != {PERF_W{1'b1}})) begin
        r_done_total <= r_done_total + PERF_W'(1);
      end
    end

    assign done_total[gi*PERF_W +: PERF_W] = r_done_total;
`endif

  end : g_ch

endmodule : iter_seq_counter

// File: tb/tb_iter_seq_counter.sv
// -----------------------------------------------------------------------------
// tb_iter_seq_counter
// Directed self-checking bench for iter_seq_counter (NUM_CH=2, CNT_W=4).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_iter_seq_counter;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        step;
  logic [NUM_CH-1:0]        abort;
  logic [NUM_CH*CNT_W-1:0]  term_cnt;
  logic [NUM_CH*CNT_W-1:0]  count;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        last;
  logic [NUM_CH-1:0]        done;
`ifdef ITER_SEQ_PERF_EN
  logic [NUM_CH*16-1:0]     done_total;
`endif

  int checks = 0;
  int errors = 0;

  iter_seq_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .abort      (abort),
    .term_cnt   (term_cnt),
    .count      (count),
    .busy       (busy),
    .last       (last),
`ifdef ITER_SEQ_PERF_EN
    .done       (done),
    .done_total (done_total)
`else
    .done       (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_term(input int ch, input logic [CNT_W-1:0] v);
    term_cnt[ch*CNT_W +: CNT_W] = v;
  endtask

  // Advance one full cycle, returning at the next falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = '0; step = '0; abort = '0; term_cnt = '0;
    tick(); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %h exp 0", count); end
    checks++; if (busy !== '0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== '0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (last !== '0)  begin errors++; $display("FAIL reset_last got %b exp 0", last); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_booth_run();
    set_term(0, 4'd7); start = 2'b01; step = 2'b01;
    tick();
    start = 2'b00;
    for (int k = 0; k < 8; k++) begin
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL booth_busy k=%0d got %b exp 1", k, busy[0]); end
      checks++; if (cnt(0) !== 4'(k)) begin errors++; $display("FAIL booth_count got %0d exp %0d", cnt(0), k); end
      checks++; if (last[0] !== (k == 7)) begin errors++; $display("FAIL booth_last k=%0d got %b exp %b", k, last[0], (k == 7)); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL booth_early_done k=%0d got %b exp 0", k, done[0]); end
      tick();
    end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL booth_done got %b exp 1", done[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL booth_busy_end got %b exp 0", busy[0]); end
    checks++; if (cnt(0) !== 4'd0)  begin errors++; $display("FAIL booth_count_end got %0d exp 0", cnt(0)); end
    step = 2'b00;
    tick();
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL booth_done_pulse got %b exp 0", done[0]); end
  endtask

  task automatic test_step_gating();
    int e;
    set_term(1, 4'd6); start = 2'b10;
    tick();
    start = 2'b00;
    e = 0;
    for (int c = 0; c <= 12; c++) begin
      checks++; if (cnt(1) !== 4'(e)) begin errors++; $display("FAIL gate_count c=%0d got %0d exp %0d", c, cnt(1), e); end
      checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL gate_busy c=%0d got %b exp 1", c, busy[1]); end
      checks++; if (done[1] !== 1'b0) begin errors++; $display("FAIL gate_done c=%0d got %b exp 0", c, done[1]); end
      step[1] = ((c % 2) == 0);
      // Mid-run start with a smaller term must not reload the run
      start[1] = (c == 3);
      if (c == 3) set_term(1, 4'd2);
      tick();
      if ((c % 2) == 0) e++;
    end
    start = 2'b00; step = 2'b00;
    checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL gate_done_end got %b exp 1", done[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL gate_busy_end got %b exp 0", busy[1]); end
    tick();
  endtask

  task automatic test_abort();
    set_term(0, 4'd5); start = 2'b01;
    tick();
    start = 2'b00; step = 2'b01;
    tick(); tick(); tick();
    checks++; if (cnt(0) !== 4'd3) begin errors++; $display("FAIL abort_pre_count got %0d exp 3", cnt(0)); end
    abort = 2'b01;
    tick();
    abort = 2'b00; step = 2'b00;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy[0]); end
    checks++; if (cnt(0) !== 4'd0)  begin errors++; $display("FAIL abort_count got %0d exp 0", cnt(0)); end
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done[0]); end
    tick();
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_done_late got %b exp 0", done[0]); end
    start = 2'b01; abort = 2'b01;
    tick();
    start = 2'b00; abort = 2'b00;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_start_busy got %b exp 0", busy[0]); end
    tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_start_busy2 got %b exp 0", busy[0]); end
  endtask

  task automatic test_boundaries();
    set_term(0, 4'd0); start = 2'b01;
    tick();
    start = 2'b00;
    checks++; if (last[0] !== 1'b1) begin errors++; $display("FAIL term0_last got %b exp 1", last[0]); end
    step = 2'b01;
    tick();
    step = 2'b00;
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL term0_done got %b exp 1", done[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL term0_busy got %b exp 0", busy[0]); end
    set_term(0, 4'd15); start = 2'b01;
    tick();
    start = 2'b00; step = 2'b01;
    for (int k = 0; k < 16; k++) begin
      checks++; if (cnt(0) !== 4'(k)) begin errors++; $display("FAIL term15_count got %0d exp %0d", cnt(0), k); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL term15_early_done k=%0d got %b exp 0", k, done[0]); end
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL term15_busy k=%0d got %b exp 1", k, busy[0]); end
      tick();
    end
    step = 2'b00;
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL term15_done got %b exp 1", done[0]); end
    checks++; if (cnt(0) !== 4'd0)  begin errors++; $display("FAIL term15_count_end got %0d exp 0", cnt(0)); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_term(0, 4'd2); set_term(1, 4'd4); start = 2'b11;
    tick();
    start = 2'b00; step = 2'b11;
    tick(); tick(); tick();
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL b2b_done0 got %b exp 1", done[0]); end
    checks++; if (cnt(1) !== 4'd3)  begin errors++; $display("FAIL b2b_count1 got %0d exp 3", cnt(1)); end
    checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b exp 1", busy[1]); end
    set_term(0, 4'd1); start = 2'b01;
    tick();
    start = 2'b00;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b exp 1", busy[0]); end
    checks++; if (cnt(0) !== 4'd0)  begin errors++; $display("FAIL b2b_restart_count got %0d exp 0", cnt(0)); end
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL b2b_restart_done got %b exp 0", done[0]); end
    checks++; if (cnt(1) !== 4'd4)  begin errors++; $display("FAIL b2b_count1_4 got %0d exp 4", cnt(1)); end
    checks++; if (last[1] !== 1'b1) begin errors++; $display("FAIL b2b_last1 got %b exp 1", last[1]); end
    tick();
    checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", done[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_busy1_end got %b exp 0", busy[1]); end
    checks++; if (cnt(0) !== 4'd1)  begin errors++; $display("FAIL b2b_count0_1 got %0d exp 1", cnt(0)); end
    checks++; if (last[0] !== 1'b1) begin errors++; $display("FAIL b2b_last0 got %b exp 1", last[0]); end
    tick();
    step = 2'b00;
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL b2b_done0_2 got %b exp 1", done[0]); end
    checks++; if (done[1] !== 1'b0) begin errors++; $display("FAIL b2b_done1_pulse got %b exp 0", done[1]); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    set_term(0, 4'd9); start = 2'b01;
    tick();
    start = 2'b00; step = 2'b01;
    tick(); tick(); tick(); tick();
    checks++; if (cnt(0) !== 4'd4) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 4", cnt(0)); end
    rst = 1'b1;
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL rstmid_count got %h exp 0", count); end
    checks++; if (busy !== '0)  begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (done !== '0)  begin errors++; $display("FAIL rstmid_done got %b exp 0", done); end
    checks++; if (last !== '0)  begin errors++; $display("FAIL rstmid_last got %b exp 0", last); end
    rst = 1'b0;
    tick();
    step = 2'b00;
    checks++; if (done !== '0) begin errors++; $display("FAIL rstmid_done_late got %b exp 0", done); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL rstmid_busy_late got %b exp 0", busy); end
  endtask

`ifdef ITER_SEQ_PERF_EN
  task automatic test_perf();
    logic [15:0] t0;
    logic [15:0] t1;
    t0 = done_total[15:0];
    checks++; if (t0 !== 16'd0) begin errors++; $display("FAIL perf_reset got %0d exp 0", t0); end
    for (int r = 0; r < 3; r++) begin
      set_term(0, 4'd1); start = 2'b01;
      tick();
      start = 2'b00; step = 2'b01;
      tick(); tick();
      step = 2'b00;
    end
    // Aborted run must not count
    start = 2'b01;
    tick();
    start = 2'b00; abort = 2'b01;
    tick();
    abort = 2'b00;
    tick();
    t0 = done_total[15:0];
    t1 = done_total[31:16];
    checks++; if (t0 !== 16'd3) begin errors++; $display("FAIL perf_ch0 got %0d exp 3", t0); end
    checks++; if (t1 !== 16'd0) begin errors++; $display("FAIL perf_ch1 got %0d exp 0", t1); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = '0; step = '0; abort = '0; term_cnt = '0;
    test_reset();
    test_booth_run();
    test_step_gating();
    test_abort();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ITER_SEQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_iter_seq_counter
